// File: rtl/i2c_reg_seq_pkg.sv
// Shared definitions for the I2C register-access sequencer: engine bit positions,
// result codes, sequencer states and the per-phase engine drive values.
package i2c_reg_seq_pkg;

   localparam int unsigned CMD_STA    = 7;
   localparam int unsigned CMD_STO    = 6;
   localparam int unsigned CMD_RD     = 5;
   localparam int unsigned CMD_WR     = 4;

   localparam int unsigned ST_ACK_N   = 7;
   localparam int unsigned ST_AL      = 5;
   localparam int unsigned ST_CMD_ACK = 4;

   typedef enum logic [1:0] {
      ERR_OK   = 2'd0,
      ERR_NACK = 2'd1,
      ERR_AL   = 2'd2,
      ERR_TO   = 2'd3
   } err_e;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_ADDR_W = 4'd1,
      S_REG    = 4'd2,
      S_DATA   = 4'd3,
      S_ADDR_R = 4'd4,
      S_READ   = 4'd5,
      S_STOP   = 4'd6,
      S_DONE   = 4'd7,
      S_GAP    = 4'd8
   } seq_state_e;

   typedef struct packed {
      logic [7:0] cmd;
      logic [7:0] din;
      logic       wr_en;
   } eng_req_t;

   // Engine command/byte presented for the whole duration of a byte phase
   function automatic eng_req_t phase_drive(seq_state_e s, logic [6:0] dev,
                                            logic [7:0] reg_a, logic [7:0] wd);
      eng_req_t r;
      r = '0;
      case (s)
         S_ADDR_W: begin
            r.cmd[CMD_STA] = 1'b1;
            r.cmd[CMD_WR]  = 1'b1;
            r.din          = {dev, 1'b0};
            r.wr_en        = 1'b1;
         end
         S_REG: begin
            r.cmd[CMD_WR] = 1'b1;
            r.din         = reg_a;
            r.wr_en       = 1'b1;
         end
         S_DATA: begin
            r.cmd[CMD_WR] = 1'b1;
            r.din         = wd;
            r.wr_en       = 1'b1;
         end
         S_ADDR_R: begin
            r.cmd[CMD_STA] = 1'b1;
            r.cmd[CMD_WR]  = 1'b1;
            r.din          = {dev, 1'b1};
            r.wr_en        = 1'b1;
         end
         S_READ:  r.cmd[CMD_RD]  = 1'b1;
         S_STOP:  r.cmd[CMD_STO] = 1'b1;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Phase that follows a successfully completed byte phase
   function automatic seq_state_e next_phase(seq_state_e s, logic rw);
      seq_state_e n;
      n = S_STOP;
      case (s)
         S_ADDR_W: n = S_REG;
         S_REG:    n = rw ? S_ADDR_R : S_DATA;
         S_ADDR_R: n = S_READ;
         default:  n = S_STOP;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/i2c_reg_seq_if.sv
// Host request/response and byte-engine signals of the register sequencer.
interface i2c_reg_seq_if;

   logic       req;
   logic       rw;
   logic [6:0] dev_addr;
   logic [7:0] reg_addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic [1:0] err;
   logic [7:0] rdata;

   logic [7:0] eng_cmd;
   logic [7:0] eng_din;
   logic       eng_wr_en;
   logic       eng_wr_done;
   logic       eng_rd_done;
   logic [7:0] eng_dout;
   logic [7:0] eng_status;

   // Sequencer side
   modport slave (
      input  req, rw, dev_addr, reg_addr, wdata,
      input  eng_wr_done, eng_rd_done, eng_dout, eng_status,
      output busy, done, err, rdata,
      output eng_cmd, eng_din, eng_wr_en
   );

   // Host plus byte-engine side
   modport master (
      output req, rw, dev_addr, reg_addr, wdata,
      output eng_wr_done, eng_rd_done, eng_dout, eng_status,
      input  busy, done, err, rdata,
      input  eng_cmd, eng_din, eng_wr_en
   );

endinterface

// File: rtl/i2c_reg_seq_timer.sv
// Per-phase timeout: loadable saturating down-counter, expired once it has run down to zero.
module i2c_reg_seq_timer #(
   parameter int unsigned TO_W = 16
) (
   input  logic            clk,
   input  logic            i_clr,
   input  logic            i_load,
   input  logic [TO_W-1:0] i_load_val,
   output logic            o_expired_c
);

   logic [TO_W-1:0] r_count;
   logic            r_armed;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_count <= '0;
         r_armed <= 1'b0;
      end else if (i_load) begin
         r_count <= i_load_val;
         r_armed <= 1'b1;
      end else if (r_count != '0) begin
         r_count <= r_count - TO_W'(1);
      end
   end

   assign o_expired_c = r_armed && (r_count == '0);

endmodule

// File: rtl/i2c_reg_seq.sv
// I2C register-access sequencer: turns one host register read/write request into the
// START/ADDR/REG/[DATA | Sr/ADDR/READ]/STOP byte-phase sequence for the I2C byte engine.
module i2c_reg_seq
   import i2c_reg_seq_pkg::*;
#(
   parameter int unsigned     TO_W        = 16,
   parameter logic [TO_W-1:0] TIMEOUT_CYC = TO_W'(50000)
) (
   input logic          clk,
   input logic          nReset,
   i2c_reg_seq_if.slave bus
);

   localparam logic [TO_W-1:0] TO_LOAD = TIMEOUT_CYC - TO_W'(1);

   seq_state_e r_state;
   seq_state_e r_next;
   eng_req_t   r_eng;
   logic       r_busy;
   logic       r_done;
   err_e       r_err;
   logic [7:0] r_rdata;
   logic [7:0] r_rd_byte;
   logic       r_rw;
   logic [6:0] r_dev;
   logic [7:0] r_reg;
   logic [7:0] r_wdata;

   logic       w_expired;
   logic       w_tmr_load;
   logic       w_al;
   logic       w_ack_n;
   logic       w_cmd_ack;
   logic       w_cmpl;
   logic       w_unused;

   assign w_al      = bus.eng_status[ST_AL];
   assign w_ack_n   = bus.eng_status[ST_ACK_N];
   assign w_cmd_ack = bus.eng_status[ST_CMD_ACK];
   assign w_cmpl    = (r_state == S_READ) ? bus.eng_rd_done : bus.eng_wr_done;
   assign w_unused  = ^{bus.eng_status[6], bus.eng_status[3:0]};

   // Reload while idle, during the inter-phase gap and on expiry, so each phase starts a fresh window
   assign w_tmr_load = (r_state == S_IDLE) || (r_state == S_GAP) || w_expired;

   i2c_reg_seq_timer #(
      .TO_W (TO_W)
   ) u_timer (
      .clk         (clk),
      .i_clr       (nReset),
      .i_load      (w_tmr_load),
      .i_load_val  (TO_LOAD),
      .o_expired_c (w_expired)
   );

   always_ff @(posedge clk) begin
      if (nReset) begin
         r_state   <= S_IDLE;
         r_next    <= S_IDLE;
         r_eng     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= ERR_OK;
         r_rdata   <= '0;
         r_rd_byte <= '0;
         r_rw      <= 1'b0;
         r_dev     <= '0;
         r_reg     <= '0;
         r_wdata   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_rw    <= bus.rw;
                  r_dev   <= bus.dev_addr;
                  r_reg   <= bus.reg_addr;
                  r_wdata <= bus.wdata;
                  r_err   <= ERR_OK;
                  r_busy  <= 1'b1;
                  r_state <= S_ADDR_W;
                  r_eng   <= phase_drive(S_ADDR_W, bus.dev_addr, bus.reg_addr, bus.wdata);
               end
            end
            S_ADDR_W, S_REG, S_DATA, S_ADDR_R, S_READ: begin
               // Lost arbitration: bus not owned, so finish without a STOP
               if (w_al) begin
                  r_err   <= ERR_AL;
                  r_eng   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_cmpl) begin
                  r_eng.cmd   <= '0;
                  r_eng.wr_en <= 1'b0;
                  r_state     <= S_GAP;
                  if (r_state == S_READ) begin
                     r_rd_byte <= bus.eng_dout;
                     r_next    <= S_STOP;
                  end else if (w_ack_n) begin
                     r_err  <= ERR_NACK;
                     r_next <= S_STOP;
                  end else begin
                     r_next <= next_phase(r_state, r_rw);
                  end
               end else if (w_expired) begin
                  r_err   <= ERR_TO;
                  r_state <= S_STOP;
                  r_eng   <= phase_drive(S_STOP, r_dev, r_reg, r_wdata);
               end
            end
            S_GAP: begin
               r_state <= r_next;
               r_eng   <= phase_drive(r_next, r_dev, r_reg, r_wdata);
            end
            S_STOP: begin
               if (w_al || w_cmd_ack || w_expired) begin
                  r_eng   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                  // An earlier error code is kept; read data is published only on a clean finish
                  if (r_err == ERR_OK) begin
                     if (w_al) begin
                        r_err <= ERR_AL;
                     end else if (!w_cmd_ack) begin
                        r_err <= ERR_TO;
                     end else if (r_rw) begin
                        r_rdata <= r_rd_byte;
                     end
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
   assign bus.rdata     = r_rdata;
   assign bus.eng_cmd   = r_eng.cmd;
   assign bus.eng_din   = r_eng.din;
   assign bus.eng_wr_en = r_eng.wr_en;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq: reactive byte-engine model plus a phase-list reference model.
module tb_i2c_reg_seq;

   localparam int F_NONE = 0;
   localparam int F_NACK = 1;
   localparam int F_AL   = 2;
   localparam int F_HANG = 3;
   localparam int TO_CYC = 16;

   logic clk = 1'b0;
   logic nReset;
   always #5 clk = ~clk;

   i2c_reg_seq_if bus ();

   i2c_reg_seq #(
      .TO_W        (16),
      .TIMEOUT_CYC (16'(TO_CYC))
   ) dut (
      .clk    (clk),
      .nReset (nReset),
      .bus    (bus)
   );

   int tests = 0;
   int fails = 0;

   // Engine configuration and observation
   int         f_mode = F_NONE;
   int         f_ph   = 0;
   logic [7:0] r_byte = 8'h00;
   logic [7:0] obs_cmd[$];
   logic [7:0] obs_din[$];
   logic       obs_wr[$];
   int         obs_len[$];
   int         gap_viol  = 0;
   int         stab_viol = 0;
   int         done_cnt  = 0;
   logic [7:0] exp_rdata = 8'h00;

   int         ph_cyc    = 0;
   int         lat       = 1;
   int         idx       = 0;
   bit         resp_prev = 1'b0;
   logic [7:0] last_cmd  = 8'h00;
   logic [7:0] last_din  = 8'h00;
   logic       last_wr   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte-engine model: completes each phase after a random latency unless told to misbehave
   always @(negedge clk) begin
      bus.eng_wr_done = 1'b0;
      bus.eng_rd_done = 1'b0;
      bus.eng_status  = 8'h00;
      bus.eng_dout    = 8'h00;
      if (bus.done === 1'b1) done_cnt++;
      if (resp_prev && bus.eng_cmd !== 8'h00) gap_viol++;
      resp_prev = 1'b0;
      if (nReset || bus.eng_cmd == 8'h00) begin
         ph_cyc = 0;
      end else begin
         if (bus.eng_cmd != last_cmd) begin
            obs_cmd.push_back(bus.eng_cmd);
            obs_din.push_back(bus.eng_din);
            obs_wr.push_back(bus.eng_wr_en);
            obs_len.push_back(0);
            ph_cyc = 0;
            lat    = $urandom_range(1, 4);
         end else if (bus.eng_din != last_din || bus.eng_wr_en != last_wr) begin
            stab_viol++;
         end
         ph_cyc++;
         idx = obs_cmd.size() - 1;
         obs_len[idx] = ph_cyc;
         if (ph_cyc == lat && !(f_mode == F_HANG && idx == f_ph)) begin
            resp_prev = 1'b1;
            if (f_mode == F_AL && idx == f_ph) begin
               bus.eng_status[5] = 1'b1;
            end else if (bus.eng_cmd == 8'h40) begin
               bus.eng_status[4] = 1'b1;
            end else if (bus.eng_cmd == 8'h20) begin
               bus.eng_rd_done = 1'b1;
               bus.eng_dout    = r_byte;
            end else begin
               bus.eng_wr_done = 1'b1;
               if (f_mode == F_NACK && idx == f_ph) bus.eng_status[7] = 1'b1;
            end
         end
      end
      last_cmd = bus.eng_cmd;
      last_din = bus.eng_din;
      last_wr  = bus.eng_wr_en;
   end

   task automatic clear_obs();
      obs_cmd.delete();
      obs_din.delete();
      obs_wr.delete();
      obs_len.delete();
      gap_viol  = 0;
      stab_viol = 0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_err"}, 32'(bus.err), 0);
      chk({tag, "_rdata"}, 32'(bus.rdata), 0);
      chk({tag, "_cmd"}, 32'(bus.eng_cmd), 0);
      chk({tag, "_din"}, 32'(bus.eng_din), 0);
      chk({tag, "_wren"}, 32'(bus.eng_wr_en), 0);
   endtask

   // One host transaction: build the expected phase list from the protocol rules, run it, compare
   task automatic run_txn(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [7:0] wd, input logic [7:0] rb,
                          input int fm, input int fp, input bit poke);
      logic [7:0] e_cmd[$];
      logic [7:0] e_din[$];
      logic       e_wr[$];
      logic [1:0] e_err;
      int         d0;
      int         n;
      bit         seen;

      e_cmd.push_back(8'h90); e_din.push_back({dev, 1'b0}); e_wr.push_back(1'b1);
      e_cmd.push_back(8'h10); e_din.push_back(ra);          e_wr.push_back(1'b1);
      if (rw) begin
         e_cmd.push_back(8'h90); e_din.push_back({dev, 1'b1}); e_wr.push_back(1'b1);
         e_cmd.push_back(8'h20); e_din.push_back(8'h00);       e_wr.push_back(1'b0);
      end else begin
         e_cmd.push_back(8'h10); e_din.push_back(wd);          e_wr.push_back(1'b1);
      end
      if (fm != F_NONE) begin
         while (e_cmd.size() > fp + 1) begin
            void'(e_cmd.pop_back());
            void'(e_din.pop_back());
            void'(e_wr.pop_back());
         end
      end
      if (fm != F_AL) begin
         e_cmd.push_back(8'h40); e_din.push_back(8'h00); e_wr.push_back(1'b0);
      end
      e_err = 2'(fm);
      if (rw && fm == F_NONE) exp_rdata = rb;

      f_mode = fm;
      f_ph   = fp;
      r_byte = rb;
      clear_obs();
      d0 = done_cnt;
      bus.req      = 1'b1;
      bus.rw       = rw;
      bus.dev_addr = dev;
      bus.reg_addr = ra;
      bus.wdata    = wd;
      @(negedge clk);
      bus.req = 1'b0;
      chk("busy_after_req", 32'(bus.busy), 1);

      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (poke && c == 3) begin
            bus.req      = 1'b1;
            bus.dev_addr = ~dev;
         end
         @(negedge clk);
         bus.req = 1'b0;
      end
      chk("done_seen", 32'(seen), 1);
      chk("busy_at_done", 32'(bus.busy), 0);
      chk("err", 32'(bus.err), 32'(e_err));
      chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
      chk("n_phases", 32'(obs_cmd.size()), 32'(e_cmd.size()));
      n = (obs_cmd.size() < e_cmd.size()) ? obs_cmd.size() : e_cmd.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("ph%0d_cmd", i), 32'(obs_cmd[i]), 32'(e_cmd[i]));
         chk($sformatf("ph%0d_wren", i), 32'(obs_wr[i]), 32'(e_wr[i]));
         if (e_wr[i]) chk($sformatf("ph%0d_din", i), 32'(obs_din[i]), 32'(e_din[i]));
      end
      if (fm == F_HANG && obs_len.size() > fp) chk("timeout_len", 32'(obs_len[fp]), 32'(TO_CYC));
      chk("gap_after_completion", 32'(gap_viol), 0);
      chk("phase_hold", 32'(stab_viol), 0);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 0);
      repeat (4) @(negedge clk);
      chk("single_done", 32'(done_cnt - d0), 1);
      f_mode = F_NONE;
   endtask

   initial begin
      bit         rw;
      int         fm;
      int         fp;
      int         nph;
      bit         reached;

      nReset       = 1'b1;
      bus.req      = 1'b0;
      bus.rw       = 1'b0;
      bus.dev_addr = 7'h00;
      bus.reg_addr = 8'h00;
      bus.wdata    = 8'h00;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      nReset = 1'b0;
      repeat (2) @(negedge clk);

      run_txn(1'b0, 7'h50, 8'h12, 8'h5A, 8'h00, F_NONE, 0, 1'b0);
      run_txn(1'b1, 7'h50, 8'h12, 8'h00, 8'hC3, F_NONE, 0, 1'b0);
      run_txn(1'b0, 7'h50, 8'h12, 8'h5A, 8'h00, F_NACK, 0, 1'b0);
      run_txn(1'b0, 7'h50, 8'h12, 8'h5A, 8'h00, F_AL,   1, 1'b0);
      run_txn(1'b0, 7'h50, 8'h12, 8'h5A, 8'h00, F_HANG, 0, 1'b0);

      // Reset while the read byte phase is outstanding
      f_mode = F_HANG;
      f_ph   = 3;
      r_byte = 8'h77;
      clear_obs();
      bus.req      = 1'b1;
      bus.rw       = 1'b1;
      bus.dev_addr = 7'h50;
      bus.reg_addr = 8'h40;
      @(negedge clk);
      bus.req = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (obs_cmd.size() >= 4) begin
            reached = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("read_phase_reached", 32'(reached), 1);
      repeat (2) @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      nReset = 1'b0;
      chk_outputs_zero("midreset");
      exp_rdata = 8'h00;
      f_mode    = F_NONE;
      repeat (2) @(negedge clk);

      run_txn(1'b1, 7'h2C, 8'h34, 8'h00, 8'h96, F_NONE, 0, 1'b1);

      for (int t = 0; t < 12; t++) begin
         rw  = 1'($urandom_range(0, 1));
         fm  = $urandom_range(0, 3);
         nph = rw ? 4 : 3;
         fp  = $urandom_range(0, nph - 1);
         if (fm == F_NACK && rw && fp == 3) fp = 2;
         run_txn(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), fm, fp,
                 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
- Register-access sequencer sitting between a host/config port and the I2C byte engine (`i2c_fsm`).
- Converts one host request (device addr, register addr, write data or read) into a sequence of byte-level commands:
  - write: START+ADDR(W), REG, DATA, STOP
  - read: START+ADDR(W), REG, repeated START+ADDR(R), READ, STOP
- Drives the engine's cmd/din/wr_en inputs and consumes its status/wr_done/rd_done/dout outputs.
- Reports completion, read data and an error code to the host.

Parameters:
- TIMEOUT_CYC, 16'd50000, clk cycles allowed per byte phase before abort.
- TO_W, 16, width of the timeout counter.

Ports:
- clk  in  1  system clock
- nReset  in  1  synchronous active-high reset
- req  in  1  host request strobe, sampled only in IDLE
- rw  in  1  1=read, 0=write
- dev_addr  in  7  7-bit slave address
- reg_addr  in  8  slave register index
- wdata  in  8  write payload
- busy  out  1  request accepted and in progress
- done  out  1  one-cycle completion pulse
- err  out  2  result code, valid with done: 0 OK, 1 NACK, 2 arbitration lost, 3 timeout
- rdata  out  8  read payload, valid with done when rw=1 and err=0
- eng_cmd  out  8  to engine cmd: [7]START [6]STOP [5]READ [4]WRITE, others 0
- eng_din  out  8  byte to transmit
- eng_wr_en  out  1  transmit byte valid
- eng_wr_done  in  1  engine pulse: byte written and ACK phase complete
- eng_rd_done  in  1  engine pulse: byte read and ACK phase complete
- eng_dout  in  8  received byte
- eng_status  in  8  {ack_n, busy, al, cmd_ack, 0, 0, transfer, int}; ack_n=1 means slave NACK

Behaviour:
- Reset (nReset=1 at posedge):
  - State goes to IDLE.
  - busy=0, done=0, err=0, rdata=0, eng_cmd=0, eng_din=0, eng_wr_en=0, timeout counter cleared.
  - A reset mid-transaction abandons the transfer. No STOP is issued; the engine is reset by the same nReset.
- All outputs are registered.
- IDLE: on req=1, latch rw/dev_addr/reg_addr/wdata and set busy=1 next cycle. req is ignored while busy=1.
- Byte phase protocol, common to all transmit/receive states:
  - eng_cmd, eng_din and eng_wr_en are held constant from the first cycle of the phase until a completion event.
  - Completion event: eng_wr_done (write phases) or eng_rd_done (read phase).
  - The cycle after completion, eng_cmd=0 and eng_wr_en=0 for exactly one gap cycle. The next phase starts the cycle after the gap.
- Phase states:
  - S_ADDR_W: cmd={START,WRITE}, din={dev_addr,1'b0}, wr_en=1.
  - S_REG: cmd=WRITE, din=reg_addr, wr_en=1.
  - S_DATA (write only): cmd=WRITE, din=wdata, wr_en=1.
  - S_ADDR_R (read only): cmd={START,WRITE} (repeated start), din={dev_addr,1'b1}, wr_en=1.
  - S_READ: cmd=READ, wr_en=0. On eng_rd_done, rdata<=eng_dout.
  - S_STOP: cmd=STOP, held until eng_status[4] (cmd_ack) is high for one cycle.
  - S_DONE: done=1 for one cycle, busy=0 the same cycle, return to IDLE.
- Transition order:
  - write: IDLE→S_ADDR_W→S_REG→S_DATA→S_STOP→S_DONE
  - read: IDLE→S_ADDR_W→S_REG→S_ADDR_R→S_READ→S_STOP→S_DONE
- Error rules, checked every cycle of a phase, in this priority:
  - Arbitration lost: eng_status[5]=1 → err=2, go directly to S_DONE with no STOP, because the bus is not owned.
  - NACK: on a write completion with eng_status[7]=1 → err=1, go to S_STOP then S_DONE.
  - Timeout: the counter reaches TIMEOUT_CYC-1 → err=3, go to S_STOP (STOP phase itself is also timed), then S_DONE.
  - A timeout during S_STOP goes straight to S_DONE and keeps the first error code.
- Timeout counter:
  - Clears on every phase entry.
  - Saturates; never wraps.
- Simultaneous events:
  - Completion and al in the same cycle: al wins.
  - Completion and timeout in the same cycle: completion wins.
- err and rdata hold their values until the next accepted request. err clears to 0 on acceptance.
- rdata is not updated for write requests or for failed reads.

Decomposition:
- Shared package `i2c_defines`:
  - cmd bit positions: STA=7, STO=6, RD=5, WR=4
  - status bit positions: ACK_N=7, AL=5, CMD_ACK=4
  - error codes: ERR_OK, ERR_NACK, ERR_AL, ERR_TO
  - sequencer state encodings
- One sub-module: `i2c_seq_timer`, a loadable saturating down-counter with a clear input and an expired output, reused per phase.

Test Plan:
- Write 0x5A to dev 0x50 reg 0x12, slave model ACKs all:
  - eng_din sequence 0xA0, 0x12, 0x5A.
  - Last byte followed by cmd=0x40.
  - done=1 with err=0 about 4 phases later; busy low the same cycle.
- Read dev 0x50 reg 0x12, slave returns 0xC3:
  - din sequence 0xA0, 0x12, 0xA1.
  - Second START asserted (cmd=0x90) on the 0xA1 phase.
  - done with err=0, rdata=0xC3.
- Write with the slave NACKing the address byte (status[7]=1 at wr_done):
  - No REG phase; STOP issued.
  - done with err=1; rdata unchanged.
- Assert status[5]=1 mid S_REG:
  - eng_cmd→0, no STOP.
  - done next cycles with err=2.
- TIMEOUT_CYC=16, engine never returns wr_done:
  - STOP issued after 16 cycles in S_ADDR_W.
  - done with err=3.
- nReset pulsed during S_READ:
  - All outputs zero the next cycle.
  - A subsequent req is accepted and completes normally.
  - A req pulsed while busy=1 is ignored (no second done).
